// File: rtl/dmem_wait_ctrl.sv
// Word RAM with byte/half/word RV32I access; response WAIT_STATES+2 cycles after accept.
// One access in flight: req_ready drops from accept until the response strobe has retired.
module dmem_wait_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault
);

    localparam int         IDX_W = $clog2(MEM_WORDS);
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef struct packed {
        logic              we;
        logic [2:0]        funct3;
        logic [IDX_W+1:0]  addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              accept, access;
    req_t              req_q;
    logic [DATA_W-1:0] mem [MEM_WORDS];

    logic [IDX_W-1:0]  idx;
    logic [1:0]        off;
    logic [DATA_W-1:0] word, shifted, load_data, wr_data;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [3:0]        be;
    logic              fault;

    // Address bits above the RAM window are deliberately ignored (wrap-around).
    logic unused_addr;
    assign unused_addr = ^req_addr[ADDR_W-1:IDX_W+2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        accept    = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    cnt_nxt   = WS;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign resp_valid = (state == RESP);

    always_ff @(posedge clk) begin
        if (accept) begin
            req_q <= '{we: req_we, funct3: req_funct3,
                       addr: req_addr[IDX_W+1:0], wdata: req_wdata};
        end
    end

    assign idx      = req_q.addr[IDX_W+1:2];
    assign off      = req_q.addr[1:0];
    assign word     = mem[idx];
    assign shifted  = word >> {off, 3'b000};
    assign byte_sel = shifted[7:0];
    assign half_sel = off[1] ? word[31:16] : word[15:0];

    // Lane decode: any fault leaves be at zero so the RAM is untouched.
    always_comb begin
        fault     = 1'b0;
        load_data = '0;
        be        = 4'b0000;
        wr_data   = '0;
        if (!req_q.we) begin
            case (req_q.funct3)
                3'b000: load_data = {{24{byte_sel[7]}}, byte_sel};
                3'b100: load_data = {24'd0, byte_sel};
                3'b001: if (off[0]) fault = 1'b1;
                        else load_data = {{16{half_sel[15]}}, half_sel};
                3'b101: if (off[0]) fault = 1'b1;
                        else load_data = {16'd0, half_sel};
                3'b010: if (off != 2'b00) fault = 1'b1;
                        else load_data = word;
                default: fault = 1'b1;
            endcase
        end else begin
            case (req_q.funct3)
                3'b000: begin
                    be      = 4'b0001 << off;
                    wr_data = {4{req_q.wdata[7:0]}};
                end
                3'b001: begin
                    if (off[0]) begin
                        fault = 1'b1;
                    end else begin
                        be      = off[1] ? 4'b1100 : 4'b0011;
                        wr_data = {2{req_q.wdata[15:0]}};
                    end
                end
                3'b010: begin
                    if (off != 2'b00) begin
                        fault = 1'b1;
                    end else begin
                        be      = 4'b1111;
                        wr_data = req_q.wdata;
                    end
                end
                default: fault = 1'b1;
            endcase
        end
    end

    // A reset landing on the access edge discards the store.
    always_ff @(posedge clk) begin
        if (access && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_rdata <= '0;
            resp_fault <= 1'b0;
        end else if (access) begin
            resp_rdata <= load_data;
            resp_fault <= fault;
        end
    end

endmodule
